pwm_capture: RTL and testbench

- Receive-side counterpart of the ALU-driven PWM generator: samples an incoming PWM waveform and recovers the 4-bit duty code (0..15) that produced it.
- Used in loopback self-check of the PWM path and to read PWM-encoded values back into the datapath.
- The expected period is fixed by a parameter. Each complete, well-formed period yields one code. Malformed periods and static lines are flagged.

---
 rtl/pwm_capture.sv | 130 +++++++++++++
 tb/tb_pwm_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: recovers the 4-bit duty code from each well-formed period of an
// asynchronous PWM input, flagging malformed periods and stuck lines.
module pwm_capture #(
  parameter int unsigned STEP_LOG2 = 0,
  parameter int unsigned CW        = STEP_LOG2 + 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [3:0] duty_val,
  output logic       duty_valid,
  output logic       period_err,
  output logic       static_lvl
);

  localparam int unsigned PERIOD = 32'd16 << STEP_LOG2;
  localparam int unsigned SAT    = 2 * PERIOD;
  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0] SAT_C    = CW'(SAT);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STATIC    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, pwm_s_q, pwm_d_q;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [3:0]    duty_val_q, duty_val_d;
  logic          duty_valid_q, duty_valid_d;
  logic          period_err_q, period_err_d;
  logic          static_lvl_q, static_lvl_d;

  logic          rise_c;
  logic          per_sat_c;
  logic [CW-1:0] h_shift_c;
  logic [3:0]    code_c;

  assign rise_c    = pwm_s_q & ~pwm_d_q;
  assign per_sat_c = (per_cnt_q == SAT_C);
  assign h_shift_c = hi_cnt_q >> STEP_LOG2;
  // A full-high period would shift to 16; clamp to the largest code.
  assign code_c    = (h_shift_c > CW'(15)) ? 4'd15 : h_shift_c[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_EDGE;
      sync1_q      <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_d_q      <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      duty_val_q   <= 4'd0;
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      static_lvl_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= pwm_in;
      pwm_s_q      <= sync1_q;
      pwm_d_q      <= pwm_s_q;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      duty_val_q   <= duty_val_d;
      duty_valid_q <= duty_valid_d;
      period_err_q <= period_err_d;
      static_lvl_q <= static_lvl_d;
    end
  end

  // Period and high-time counters restart on every rising edge and saturate.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise_c) begin
      per_cnt_d = CW'(1);
      hi_cnt_d  = CW'(1);
    end else begin
      if (!per_sat_c) per_cnt_d = per_cnt_q + CW'(1);
      if (pwm_s_q && (hi_cnt_q != SAT_C)) hi_cnt_d = hi_cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    duty_val_d   = duty_val_q;
    duty_valid_d = 1'b0;
    period_err_d = 1'b0;
    static_lvl_d = 1'b0;
    unique case (state_q)
      WAIT_EDGE: begin
        if (rise_c) begin
          state_d = MEASURE;
        end else if (per_sat_c) begin
          state_d      = STATIC;
          duty_val_d   = pwm_s_q ? 4'd15 : 4'd0;
          duty_valid_d = 1'b1;
        end
      end
      MEASURE: begin
        if (rise_c) begin
          if (per_cnt_q == PERIOD_C) begin
            duty_val_d   = code_c;
            duty_valid_d = 1'b1;
          end else begin
            period_err_d = 1'b1;
          end
        end else if (per_sat_c) begin
          state_d      = STATIC;
          duty_val_d   = pwm_s_q ? 4'd15 : 4'd0;
          duty_valid_d = 1'b1;
        end
      end
      STATIC: begin
        // The unbounded period ending at this rise is never reported.
        if (rise_c) state_d = MEASURE;
        else        static_lvl_d = 1'b1;
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  assign duty_val   = duty_val_q;
  assign duty_valid = duty_valid_q;
  assign period_err = period_err_q;
  assign static_lvl = static_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven code vectors, hand-written corner sequences
// and random waveforms, all checked cycle by cycle against a sample-level model.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm0, pwm2;
  logic [3:0] val0, val2;
  logic       dv0, dv2, pe0, pe2, sl0, sl2;

  always #5 clk = ~clk;

  pwm_capture #(.STEP_LOG2(0)) u_dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm0),
    .duty_val(val0), .duty_valid(dv0), .period_err(pe0), .static_lvl(sl0));

  pwm_capture #(.STEP_LOG2(2)) u_dut2 (
    .clk(clk), .rst(rst), .pwm_in(pwm2),
    .duty_val(val2), .duty_valid(dv2), .period_err(pe2), .static_lvl(sl2));

  typedef struct {
    int sel;
    int high;
    int periods;
    int exp_pulses;
    int exp_val;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         sel = 0;
  bit         wave[$];
  logic [6:0] exp_q[$];
  logic [3:0] obs_vals[$];
  int         obs_err;
  logic       last_static;

  function automatic logic [6:0] dut_out();
    return (sel != 0) ? {val2, dv2, pe2, sl2} : {val0, dv0, pe0, sl0};
  endfunction

  function automatic logic [4:0] obs_at(input int k);
    return (obs_vals.size() > k) ? {1'b0, obs_vals[k]} : 5'h1F;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add_period(input int len, input int high);
    for (int i = 0; i < len; i++) wave.push_back(i < high);
  endtask

  task automatic add_level(input int len, input bit lvl);
    for (int i = 0; i < len; i++) wave.push_back(lvl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pwm0 = 1'b0;
    pwm2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Sample-level reference: wave[k] is the level seen at clock edge k after
  // reset release; a rise at sample r is acted on at edge r+2. Result entry e
  // is {duty_val, duty_valid, period_err, static_lvl} after edge e.
  task automatic build_model(input int s_log2);
    int         p    = 16 << s_log2;
    int         mode = 0;  // 0 waiting for first edge, 1 measuring, 2 stuck
    int         last = 0;
    logic [3:0] val  = 4'd0;
    exp_q.delete();
    for (int e = 0; e < wave.size(); e++) begin
      bit cur, prv, rise, v, er, st;
      int n, h, code;
      cur  = (e >= 2) ? wave[e-2] : 1'b0;
      prv  = (e >= 3) ? wave[e-3] : 1'b0;
      rise = cur & ~prv;
      v    = 1'b0;
      er   = 1'b0;
      st   = (mode == 2) && !rise;
      if (rise) begin
        if (mode == 1) begin
          n = e - last;
          h = 0;
          for (int k = last - 2; k < e - 2; k++) h += int'(wave[k]);
          if (n == p) begin
            code = h / (1 << s_log2);
            if (code > 15) code = 15;
            val = 4'(code);
            v   = 1'b1;
          end else begin
            er = 1'b1;
          end
        end
        mode = 1;
        last = e;
      end else if (mode != 2 && (e - last) >= 2 * p) begin
        val  = cur ? 4'd15 : 4'd0;
        v    = 1'b1;
        mode = 2;
      end
      exp_q.push_back({val, v, er, st});
    end
  endtask

  // Drives the wave from the current negedge and checks every edge.
  task automatic run_wave(input string tag);
    logic [6:0] o;
    build_model((sel != 0) ? 2 : 0);
    obs_vals.delete();
    obs_err = 0;
    for (int e = 0; e < wave.size(); e++) begin
      pwm0 = (sel == 0) ? wave[e] : 1'b0;
      pwm2 = (sel != 0) ? wave[e] : 1'b0;
      @(negedge clk);
      o = dut_out();
      checks++;
      if (o !== exp_q[e]) begin
        failures++;
        $display("FAIL %s edge=%0d got{val,vld,err,stat}=%h_%b%b%b exp=%h_%b%b%b",
                 tag, e, o[6:3], o[2], o[1], o[0],
                 exp_q[e][6:3], exp_q[e][2], exp_q[e][1], exp_q[e][0]);
      end
      if (o[2]) obs_vals.push_back(o[6:3]);
      if (o[1]) obs_err++;
      last_static = o[0];
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   p;
    tbl[0] = '{sel: 0, high: 2,  periods: 5, exp_pulses: 4, exp_val: 2};
    tbl[1] = '{sel: 1, high: 4,  periods: 3, exp_pulses: 2, exp_val: 1};
    tbl[2] = '{sel: 1, high: 28, periods: 3, exp_pulses: 2, exp_val: 7};
    tbl[3] = '{sel: 1, high: 60, periods: 3, exp_pulses: 2, exp_val: 15};
    tbl[4] = '{sel: 0, high: 15, periods: 4, exp_pulses: 3, exp_val: 15};
    tbl[5] = '{sel: 0, high: 1,  periods: 4, exp_pulses: 3, exp_val: 1};
    tbl[6] = '{sel: 0, high: 8,  periods: 3, exp_pulses: 2, exp_val: 8};

    rst = 1'b0;
    pwm0 = 1'b0;
    pwm2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out0", {val0, dv0, pe0, sl0}, 32'd0);
    check("reset_out2", {val2, dv2, pe2, sl2}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      sel = tbl[i].sel;
      p = 16 << ((sel != 0) ? 2 : 0);
      do_reset();
      wave.delete();
      repeat (tbl[i].periods) add_period(p, tbl[i].high);
      add_level(3, 1'b0);
      run_wave($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_pulses", i), obs_vals.size(), tbl[i].exp_pulses);
      check($sformatf("tbl%0d_val", i), dut_out() >> 3, tbl[i].exp_val);
      check($sformatf("tbl%0d_err", i), obs_err, 0);
    end

    // One 17-cycle period inside a code-5 stream.
    sel = 0;
    do_reset();
    wave.delete();
    repeat (3) add_period(16, 5);
    add_period(17, 5);
    repeat (2) add_period(16, 5);
    add_level(3, 1'b0);
    run_wave("perr");
    check("perr_count", obs_err, 1);
    check("perr_pulses", obs_vals.size(), 4);
    check("perr_val", dut_out() >> 3, 5);

    // Static low after code 3, then recovery at code 9.
    do_reset();
    wave.delete();
    repeat (3) add_period(16, 3);
    add_level(40, 1'b0);
    repeat (3) add_period(16, 9);
    add_level(3, 1'b0);
    run_wave("slow");
    check("slow_pulses", obs_vals.size(), 5);
    check("slow_static_code", obs_at(2), 0);
    check("slow_recovered", obs_at(4), 9);
    check("slow_lvl_end", last_static, 0);

    // Static high.
    do_reset();
    wave.delete();
    repeat (2) add_period(16, 6);
    add_level(40, 1'b1);
    run_wave("shigh");
    check("shigh_pulses", obs_vals.size(), 3);
    check("shigh_code", obs_at(2), 15);
    check("shigh_lvl_end", last_static, 1);

    // Async reset mid-period at code 4.
    do_reset();
    wave.delete();
    repeat (3) add_period(16, 4);
    add_period(8, 4);
    run_wave("arst_pre");
    check("arst_pre_val", dut_out() >> 3, 4);
    #2 rst = 1'b0;
    #1 check("arst_immediate", dut_out(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wave.delete();
    repeat (3) add_period(16, 4);
    add_level(3, 1'b0);
    run_wave("arst_post");
    check("arst_pulses", obs_vals.size(), 2);
    check("arst_val", obs_at(0), 4);

    // Random waveforms mixing good periods, malformed periods and stuck lines.
    for (int it = 0; it < 8; it++) begin
      int segs, r, len;
      sel = int'($urandom_range(0, 1));
      p = 16 << ((sel != 0) ? 2 : 0);
      do_reset();
      wave.delete();
      segs = int'($urandom_range(6, 10));
      for (int s = 0; s < segs; s++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6) begin
          add_period(p, int'($urandom_range(1, p - 1)));
        end else if (r < 8) begin
          len = p + (($urandom_range(0, 1) != 0) ? 1 : -1) * int'($urandom_range(1, 3));
          add_period(len, int'($urandom_range(1, len - 1)));
        end else begin
          add_level(2 * p + int'($urandom_range(1, p)), 1'($urandom_range(0, 1)));
        end
      end
      add_level(4, 1'b0);
      run_wave($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
